icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache; the responder end of the fetch-stage ICACHE_* interface.
//  - Serves 32-bit instruction words to the fetch stage.
//  - Stalls the fetch stage on a miss and refills one 4-word line from memory.
//  - Sits between the fetch stage (proc_*) and the instruction memory / arbiter (mem_*).
// PARAMETERS
//  NUM_LINES  8   number of cache lines; power of 2, >=2; IDX_W = log2(NUM_LINES)
//  ADDR_W     30  processor word-address width; TAG_W = ADDR_W-2-IDX_W
// PORTS
//  clk           in   1    clock; all state updates on rising edge
//  proc_reset    in   1    reset; synchronous, active-high
//  proc_read     in   1    fetch request (ICACHE_ren)
//  proc_write    in   1    write request (ICACHE_wen); ignored, read-only cache
//  proc_addr     in   30   word address (ICACHE_addr = pc[31:2])
//  proc_wdata    in   32   write data; ignored
//  proc_rdata    out  32   instruction word; valid when proc_read & !proc_stall
//  proc_stall    out  1    1 = fetch stage must hold pc and retry
//  mem_read      out  1    line-refill request to memory
//  mem_write     out  1    tied 0
//  mem_addr      out  28   line address = proc_addr[29:2] latched at miss
//  mem_wdata     out  128  tied 0
//  mem_rdata     in   128  refill line; word0 = [31:0] ... word3 = [127:96]
//  mem_ready     in   1    1-cycle strobe: mem_rdata valid this cycle
//  perf_hit_cnt  out  32   hit counter (ICACHE_PERF_EN), else 0
//  perf_miss_cnt out  32   miss counter (ICACHE_PERF_EN), else 0
// BEHAVIOUR
//  Address split: offset=proc_addr[1:0], index=proc_addr[IDX_W+1:2], tag=proc_addr[ADDR_W-1:IDX_W+2].
//  Storage: per line valid(1), tag(TAG_W), data(128); flops, no SRAM macro.
//  hit = proc_read & valid[index] & (tag_arr[index]==tag); purely combinational, 0-cycle latency.
//  Hit read: proc_rdata = data[index][32*offset +: 32], passed raw (fetch stage does byte swap).
//  FSM states IDLE, FETCH. Reset state IDLE.
//   - IDLE, !proc_read: proc_stall=0, no state change.
//   - IDLE, hit: proc_stall=0, stay IDLE.
//   - IDLE, miss: proc_stall=1 combinationally in the same cycle; latch mem_addr=proc_addr[29:2]; next state FETCH.
//   - FETCH: mem_read=1, proc_stall=1. mem_addr is held constant.
//     On mem_ready=1: write data, tag and valid=1 into line mem_addr[IDX_W-1:0]; next state IDLE.
//   - Cycle after refill: the lookup hits and proc_stall drops.
//  Miss penalty = 1 (request) + memory latency + 1 (re-lookup) cycles.
//  mem_read is a registered level: it rises the cycle after the miss and falls the cycle after mem_ready.
//  Boundary conditions:
//   - mem_ready while IDLE is ignored.
//   - proc_addr is required stable while proc_stall=1. If it changes, the fill still targets the latched
//     mem_addr and the new address is looked up afresh in IDLE.
//   - Refilling line i overwrites any valid line i (conflict eviction); no writeback.
//   - proc_write=1 has no effect on state or outputs.
//   - proc_reset mid-FETCH: state -> IDLE and mem_read=0 at that edge; the in-flight line is discarded.
//  Reset values:
//   - all valid=0, state=IDLE, mem_read=0, mem_addr=0, perf counters=0.
//   - proc_stall=0 while proc_reset=1.
//   - tag/data arrays are not reset.
// CONFIGURATION
//  ICACHE_PERF_EN defined:
//   - perf_hit_cnt +1 each cycle with IDLE & hit.
//   - perf_miss_cnt +1 on each IDLE->FETCH transition.
//   - both saturate at 32'hFFFF_FFFF; both cleared by proc_reset.
//  ICACHE_PERF_EN undefined: no counter flops; both ports are constant 0. All other behaviour is identical.
// TESTING
//  1 Cold miss:
//    - reset, proc_read=1, addr=30'h10 -> proc_stall=1 same cycle; mem_read=1 next cycle with mem_addr=28'h4.
//    - mem_ready after 3 cycles with line {D3,D2,D1,D0} -> next cycle stall=0, proc_rdata=D0.
//  2 Line hits: after test 1, addr 30'h11/12/13 on consecutive cycles -> stall=0 each cycle, rdata=D1/D2/D3,
//    mem_read stays 0.
//  3 Conflict: NUM_LINES=8; fill addr 30'h10, then addr 30'h30 (same index 4, new tag) -> miss, refill.
//    Re-access 30'h10 -> miss again.
//  4 Reset mid-refill: assert proc_reset while in FETCH -> mem_read=0 next cycle.
//    Later mem_ready pulse is ignored; addr 30'h10 still misses.
//  5 Idle/write: proc_read=0, proc_write=1, random addr for 20 cycles -> proc_stall=0, mem_read=0, no valid set.
//  6 Perf (ICACHE_PERF_EN): run tests 1+2 -> perf_miss_cnt=1, perf_hit_cnt=4. Without macro, both read 0.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-stage / memory-side signal bundle for icache_dm.
// slave = the cache's view, master = the fetch stage plus memory side as seen by the environment.
interface icache_dm_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 4-word lines and single-line refill.
// Optional hit/miss performance counters when ICACHE_PERF_EN is defined.
module icache_dm #(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned ADDR_W    = 30
) (
    input  logic        clk,
    input  logic        proc_reset,
    icache_dm_if.slave  bus,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned LINE_W = ADDR_W - 2;
    localparam int unsigned TAG_W  = ADDR_W - 2 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state;
    state_t             state_nx;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]   tag_arr  [NUM_LINES];
    logic [127:0]       data_arr [NUM_LINES];
    logic [LINE_W-1:0]  mem_addr_q;

    logic [1:0]         offset;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic               hit;
    logic               stall;
    logic               miss_start;
    logic               fill;

    assign offset   = bus.proc_addr[1:0];
    assign idx      = bus.proc_addr[IDX_W+1:2];
    assign tag      = bus.proc_addr[ADDR_W-1:IDX_W+2];
    assign fill_idx = mem_addr_q[IDX_W-1:0];
    assign hit      = bus.proc_read & valid[idx] & (tag_arr[idx] == tag);

    // Next-state and stall decode
    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.proc_read && !hit) begin
                    stall      = 1'b1;
                    miss_start = 1'b1;
                    state_nx   = FETCH;
                end
            end
            FETCH: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    fill     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Reset wins: no stall, and an in-flight line is dropped
        if (proc_reset) begin
            stall      = 1'b0;
            miss_start = 1'b0;
            fill       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state      <= IDLE;
            valid      <= '0;
            mem_addr_q <= '0;
        end else begin
            state <= state_nx;
            if (miss_start) mem_addr_q <= bus.proc_addr[ADDR_W-1:2];
            if (fill) valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; valid bits gate its use
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[fill_idx]  <= mem_addr_q[LINE_W-1:IDX_W];
            data_arr[fill_idx] <= bus.mem_rdata;
        end
    end

    assign bus.proc_rdata = data_arr[idx][{offset, 5'd0} +: 32];
    assign bus.proc_stall = stall;
    assign bus.mem_read   = (state == FETCH);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = '0;

    logic unused_wr;
    assign unused_wr = ^{bus.proc_write, bus.proc_wdata};

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && hit && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_start && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign perf_hit_cnt  = hit_cnt;
    assign perf_miss_cnt = miss_cnt;
`else
    assign perf_hit_cnt  = '0;
    assign perf_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm against a line-address reference model.
module tb_icache_dm;
    localparam int unsigned NL = 8;

    logic        clk;
    logic        proc_reset;
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;

    icache_dm_if #(.ADDR_W(30)) bus ();

    icache_dm #(.NUM_LINES(NL), .ADDR_W(30)) dut (
        .clk           (clk),
        .proc_reset    (proc_reset),
        .bus           (bus),
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which memory line each cache slot holds
    logic         m_valid [NL];
    logic [27:0]  m_line  [NL];
    logic [127:0] m_data  [NL];
    int           m_hits;
    int           m_misses;

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One fetch of addr; on a miss, memory answers after lat cycles with a random line
    task automatic access(input logic [29:0] addr, input int lat, input string name);
        logic [27:0]  line;
        int           idx;
        logic         exp_hit;
        logic [127:0] fill_data;
        logic [31:0]  exp_word;
        line    = addr >> 2;
        idx     = int'(line % NL);
        exp_hit = m_valid[idx] && (m_line[idx] == line);
        @(posedge clk); #1;
        bus.proc_read = 1'b1;
        bus.proc_addr = addr;
        @(negedge clk);
        checks++;
        if (bus.proc_stall !== !exp_hit) begin
            errors++;
            $display("FAIL %s lookup stall got %0b exp %0b addr %h", name, bus.proc_stall, !exp_hit, addr);
        end
        if (exp_hit) begin
            exp_word = 32'(m_data[idx] >> (32 * (addr % 4)));
            m_hits++;
            checks++;
            if (bus.proc_rdata !== exp_word) begin
                errors++;
                $display("FAIL %s hit rdata got %h exp %h", name, bus.proc_rdata, exp_word);
            end
            return;
        end
        m_misses++;
        fill_data = rand_line();
        @(posedge clk); #1;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== line || bus.proc_stall !== 1'b1) begin
                errors++;
                $display("FAIL %s fetch wait got rd %0b addr %h stall %0b exp rd 1 addr %h stall 1",
                         name, bus.mem_read, bus.mem_addr, bus.proc_stall, line);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = fill_data;
        @(negedge clk);
        checks++;
        if (bus.mem_read !== 1'b1 || bus.proc_stall !== 1'b1 || bus.mem_addr !== line) begin
            errors++;
            $display("FAIL %s ready cycle got rd %0b stall %0b addr %h exp rd 1 stall 1 addr %h",
                     name, bus.mem_read, bus.proc_stall, bus.mem_addr, line);
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = rand_line();
        m_valid[idx] = 1'b1;
        m_line[idx]  = line;
        m_data[idx]  = fill_data;
        exp_word     = 32'(fill_data >> (32 * (addr % 4)));
        m_hits++;
        @(negedge clk);
        checks++;
        if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.proc_rdata !== exp_word) begin
            errors++;
            $display("FAIL %s relookup got stall %0b rd %0b data %h exp stall 0 rd 0 data %h",
                     name, bus.proc_stall, bus.mem_read, bus.proc_rdata, exp_word);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        proc_reset    = 1'b1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'($urandom());
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0) begin
            errors++;
            $display("FAIL reset outputs got stall %0b rd %0b addr %h exp 0 0 0",
                     bus.proc_stall, bus.mem_read, bus.mem_addr);
        end
        checks++;
        if (perf_hit_cnt !== 32'h0 || perf_miss_cnt !== 32'h0 || bus.mem_write !== 1'b0 || bus.mem_wdata !== 128'h0) begin
            errors++;
            $display("FAIL reset perf/tie got hit %0d miss %0d wr %0b exp 0 0 0",
                     perf_hit_cnt, perf_miss_cnt, bus.mem_write);
        end
        @(posedge clk); #1;
        proc_reset    = 1'b0;
        bus.proc_read = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss_and_line_hits();
        access(30'h10, 3, "cold_miss");
        access(30'h11, 0, "line_hit1");
        access(30'h12, 0, "line_hit2");
        access(30'h13, 0, "line_hit3");
        checks++;
        if (bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL line_hits mem_read got %0b exp 0", bus.mem_read);
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_h;
        logic [31:0] exp_m;
`ifdef ICACHE_PERF_EN
        exp_h = 32'd4;
        exp_m = 32'd1;
`else
        exp_h = 32'd0;
        exp_m = 32'd0;
`endif
        test_reset();
        test_cold_miss_and_line_hits();
        @(posedge clk); #1;
        bus.proc_read = 1'b0;
        @(negedge clk);
        checks++;
        if (perf_hit_cnt !== exp_h || perf_miss_cnt !== exp_m) begin
            errors++;
            $display("FAIL perf got hit %0d miss %0d exp hit %0d miss %0d",
                     perf_hit_cnt, perf_miss_cnt, exp_h, exp_m);
        end
    endtask

    task automatic test_conflict();
        access(30'h10, 1, "conflict_a");
        access(30'h30, 2, "conflict_b");
        access(30'h10, 1, "conflict_a_again");
        checks++;
        if (m_misses < 2) begin
            errors++;
            $display("FAIL conflict model misses got %0d exp >=2", m_misses);
        end
    endtask

    task automatic test_reset_mid_refill();
        test_reset();
        @(posedge clk); #1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h10;
        @(posedge clk); #1;
        proc_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.proc_stall !== 1'b0) begin
            errors++;
            $display("FAIL midreset stall got %0b exp 0", bus.proc_stall);
        end
        @(posedge clk); #1;
        proc_reset    = 1'b0;
        bus.proc_read = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL midreset mem_read got %0b exp 0", bus.mem_read);
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rand_line();
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        model_clear();
        access(30'h10, 2, "after_midreset");
    endtask

    task automatic test_idle_write();
        test_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.proc_read  = 1'b0;
            bus.proc_write = 1'b1;
            bus.proc_addr  = 30'($urandom());
            bus.proc_wdata = $urandom();
            bus.mem_ready  = 1'($urandom_range(0, 1));
            bus.mem_rdata  = rand_line();
            @(negedge clk);
            checks++;
            if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin
                errors++;
                $display("FAIL idle_write cyc %0d got stall %0b rd %0b exp 0 0", i, bus.proc_stall, bus.mem_read);
            end
        end
        @(posedge clk); #1;
        bus.proc_write = 1'b0;
        bus.mem_ready  = 1'b0;
        access(30'($urandom()), 1, "idle_write_nofill");
    endtask

    task automatic test_random();
        logic [29:0] pool [6];
        logic [31:0] exp_h;
        logic [31:0] exp_m;
        test_reset();
        for (int i = 0; i < 6; i++) pool[i] = 30'($urandom_range(0, 255));
        for (int i = 0; i < 60; i++)
            access(pool[$urandom_range(0, 5)] ^ 30'($urandom_range(0, 3)), $urandom_range(0, 4), "random");
        @(posedge clk); #1;
        bus.proc_read = 1'b0;
`ifdef ICACHE_PERF_EN
        exp_h = 32'(m_hits);
        exp_m = 32'(m_misses);
`else
        exp_h = 32'd0;
        exp_m = 32'd0;
`endif
        @(negedge clk);
        checks++;
        if (perf_hit_cnt !== exp_h || perf_miss_cnt !== exp_m) begin
            errors++;
            $display("FAIL random perf got hit %0d miss %0d exp hit %0d miss %0d",
                     perf_hit_cnt, perf_miss_cnt, exp_h, exp_m);
        end
    endtask

    initial begin
        proc_reset     = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        model_clear();
        test_reset();
        test_cold_miss_and_line_hits();
        test_conflict();
        test_reset_mid_refill();
        test_idle_write();
        test_perf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
